// File: rtl/mac_responder_if.sv
// Bundles the controller handshake and the operand-memory read port of the MAC responder.
interface mac_responder_if #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int ACCW = 2*DW+AW
);
    logic            rd;
    logic            act;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_a;
    logic [DW-1:0]   mem_b;
    logic            busy;
    logic            done;
    logic [ACCW-1:0] result;
    logic            result_valid;

    modport slave (
        input  rd, act, mem_a, mem_b,
        output mem_en, mem_addr, busy, done, result, result_valid
    );

    modport master (
        output rd, act, mem_a, mem_b,
        input  mem_en, mem_addr, busy, done, result, result_valid
    );
endinterface

// File: rtl/mac_responder.sv
// Responder for the rd/act/done handshake: fetches LEN operand pairs and
// multiply-accumulates them, parking at most one returned pair while act is low.
module mac_responder #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int LEN  = 16,
    parameter int ACCW = 2*DW+AW
) (
    input logic            clk,
    input logic            rst_n,
    mac_responder_if.slave bus
);
    localparam int           CW    = AW+1;
    localparam logic [CW-1:0] LEN_C = CW'(LEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic            rd_q;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   consumed;
    logic            dvalid;
    logic            hold_full;
    logic [DW-1:0]   hold_a;
    logic [DW-1:0]   hold_b;
    logic [ACCW-1:0] acc;
    logic            busy;
    logic            done;
    logic [ACCW-1:0] result;
    logic            result_valid;

    logic            hold_free_next;
    logic            issue;
    logic            take_hold;
    logic            take_new;
    logic            consume;
    logic            park;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] acc_next;

    // A read is only issued if the hold slot will be free after this edge, so the
    // data it returns can always be parked even if act is low on arrival.
    assign hold_free_next = hold_full ? (bus.act && !dvalid) : !(dvalid && !bus.act);
    assign issue          = (state == RUN) && bus.rd && (issued < LEN_C) && hold_free_next;

    assign take_hold = hold_full && bus.act;
    assign take_new  = dvalid && bus.act && !hold_full;
    assign consume   = take_hold || take_new;
    assign park      = dvalid && (!bus.act || hold_full);

    assign op_a     = hold_full ? hold_a : bus.mem_a;
    assign op_b     = hold_full ? hold_b : bus.mem_b;
    assign prod     = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
    assign acc_next = acc + ACCW'(prod);

    assign bus.mem_en       = issue;
    assign bus.mem_addr     = issued[AW-1:0];
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_q         <= 1'b0;
            issued       <= '0;
            consumed     <= '0;
            dvalid       <= 1'b0;
            hold_full    <= 1'b0;
            hold_a       <= '0;
            hold_b       <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            // Outside IDLE rd_q is forced high so a restart needs a fresh low sample in IDLE.
            rd_q   <= (state == IDLE) ? bus.rd : 1'b1;
            dvalid <= issue;
            case (state)
                IDLE: begin
                    if (bus.rd && !rd_q) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        acc          <= '0;
                        issued       <= '0;
                        consumed     <= '0;
                        hold_full    <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (issue)
                        issued <= issued + CW'(1);
                    if (park) begin
                        hold_full <= 1'b1;
                        hold_a    <= bus.mem_a;
                        hold_b    <= bus.mem_b;
                    end else if (take_hold) begin
                        hold_full <= 1'b0;
                    end
                    if (consume) begin
                        acc      <= acc_next;
                        consumed <= consumed + CW'(1);
                        if (consumed == LEN_C - CW'(1)) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            result       <= acc_next;
                            result_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    hold_full <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
